// File: rtl/fp_norm_align_shifter_pkg.sv
// Shared types and constants for the multi-cycle FP mantissa align/normalise shifter.
package fp_shift_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_CHECK = 2'd1,
        SHIFT      = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    function automatic int grs_width();
        return 3;
    endfunction

endpackage

// File: rtl/fp_norm_align_shifter_step_lzc.sv
// Leading-zero count over a STEP-bit window, saturating at STEP when the window is all zero.
module step_lzc #(
    parameter int STEP = 4,
    parameter int CW   = $clog2(STEP + 1)
) (
    input  logic [STEP-1:0] bits,
    output logic [CW-1:0]   lz
);

    always_comb begin
        lz = CW'(STEP);
        // Scan LSB to MSB so the highest set bit has the final say.
        for (int i = 0; i < STEP; i++) begin
            if (bits[i]) begin
                lz = CW'(STEP - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_align_shifter.sv
// Multi-cycle mantissa shifter: right alignment with sticky tracking, left normalisation
// with an optional shift limit, moving at most STEP positions per clock.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// IDLE       | waiting for start; outputs hold the last result
// LOAD_CHECK | operands latched; detect saturated right shift / all-zero left input
// SHIFT      | one step per clock until the amount, MSB or limit terminates
// DONE       | done pulse; results valid, return to IDLE
module fp_norm_align_shifter
    import fp_shift_pkg::*;
#(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int STEP          = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     direction,
    input  logic [Mantissa_Size:0]   unshifted,
    input  logic [2:0]               grs_in,
    input  logic [Exponent_Size-1:0] no_of_shifts,
    output logic [Mantissa_Size:0]   shifted,
    output logic [2:0]               grs,
    output logic [Exponent_Size-1:0] shift_count,
    output logic                     zero,
    output logic                     limited,
    output logic                     busy,
    output logic                     done
);

    localparam int W  = Mantissa_Size + 1;
    localparam int GW = grs_width();
    localparam int EW = W + GW;
    localparam int CW = $clog2(STEP + 1);
    localparam logic [Exponent_Size-1:0] STEP_K = Exponent_Size'(STEP);
    localparam logic [Exponent_Size-1:0] SAT_N  = Exponent_Size'(EW);

    state_t                   state;
    logic [EW-1:0]            e_q;
    logic [Exponent_Size-1:0] rem_q;
    logic [Exponent_Size-1:0] count_q;
    logic                     dir_q;
    logic                     zero_q;
    logic                     limited_q;
    logic                     term_q;

    logic [CW-1:0]            lz;
    logic [Exponent_Size-1:0] k_right;
    logic [Exponent_Size-1:0] k_left;
    logic [EW-1:0]            right_mask;
    logic [EW-1:0]            e_right;
    logic [EW-1:0]            e_left;

    step_lzc #(.STEP(STEP), .CW(CW)) u_lzc (
        .bits (e_q[EW-1 -: STEP]),
        .lz   (lz)
    );

    always_comb begin
        k_right    = (rem_q < STEP_K) ? rem_q : STEP_K;
        k_left     = (Exponent_Size'(lz) < rem_q) ? Exponent_Size'(lz) : rem_q;
        right_mask = ~({EW{1'b1}} << k_right);
        e_right    = e_q >> k_right;
        // Every bit leaving the register, the old sticky included, folds into the new sticky.
        e_right[0] = e_right[0] | (|(e_q & right_mask));
        e_left     = {e_q[EW-1:1] << k_left, e_q[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            e_q       <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            dir_q     <= DIR_LEFT;
            zero_q    <= 1'b0;
            limited_q <= 1'b0;
            term_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        e_q       <= {unshifted, grs_in};
                        rem_q     <= no_of_shifts;
                        count_q   <= '0;
                        dir_q     <= direction;
                        zero_q    <= 1'b0;
                        limited_q <= 1'b0;
                        term_q    <= 1'b0;
                        state     <= LOAD_CHECK;
                    end
                end
                LOAD_CHECK: begin
                    // Early-exit cases still pass through SHIFT so their latency is fixed at 3.
                    state <= SHIFT;
                    if (dir_q == DIR_RIGHT) begin
                        if (rem_q >= SAT_N) begin
                            e_q     <= {{(EW-1){1'b0}}, |e_q};
                            count_q <= rem_q;
                            rem_q   <= '0;
                            term_q  <= 1'b1;
                        end
                    end else if (e_q[EW-1:1] == '0) begin
                        zero_q <= 1'b1;
                        term_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (term_q) begin
                        state <= DONE;
                    end else if (dir_q == DIR_RIGHT) begin
                        if (rem_q == '0) begin
                            state <= DONE;
                        end else begin
                            e_q     <= e_right;
                            rem_q   <= rem_q - k_right;
                            count_q <= count_q + k_right;
                        end
                    end else begin
                        if (e_q[EW-1]) begin
                            state <= DONE;
                        end else if (rem_q == '0) begin
                            limited_q <= 1'b1;
                            state     <= DONE;
                        end else begin
                            e_q     <= e_left;
                            rem_q   <= rem_q - k_left;
                            count_q <= count_q + k_left;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign shifted     = e_q[EW-1:GW];
    assign grs         = e_q[GW-1:0];
    assign shift_count = count_q;
    assign zero        = zero_q;
    assign limited     = limited_q;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: doc/fp_norm_align_shifter.md
# fp_norm_align_shifter

Multi-cycle, parametrised mantissa shifter for the FP ALU. It performs two jobs. Right-shift alignment keeps full guard/round/sticky (GRS) tracking. Left-shift normalisation is optionally capped by a shift limit, for denormal outputs. It shifts up to STEP bit positions per clock and hands results to the adder/subtractor and multiplier datapaths through a start/busy/done handshake.

## Interface
Parameters:
- Mantissa_Size, default 23: mantissa field width. The datapath width is W = Mantissa_Size+1, including the hidden bit.
- Exponent_Size, default 8: width of the shift-amount and count fields. Must satisfy 2^Exponent_Size > W+3.
- STEP, default 4: maximum bit positions moved per clock. Power of two, 1 ≤ STEP ≤ W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only while busy=0.
- direction  in  1  1 = right shift (align), 0 = left shift (normalise).
- unshifted  in  W  input mantissa.
- grs_in  in  3  incoming guard, round, sticky bits.
- no_of_shifts  in  Exponent_Size  right: exact shift amount. Left: maximum shift allowed.
- shifted  out  W  result mantissa.
- grs  out  3  result guard, round, sticky bits.
- shift_count  out  Exponent_Size  positions actually shifted.
- zero  out  1  left mode: input {unshifted, grs_in[2:1]} was all zero.
- limited  out  1  left mode: stopped on the limit before the MSB became 1.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when results are valid.

## Operation
- FSM states: IDLE, LOAD_CHECK, SHIFT, DONE.
  - IDLE --start--> LOAD_CHECK.
  - LOAD_CHECK --> SHIFT.
  - SHIFT --terminate--> DONE.
  - DONE --> IDLE.
- Internal register E = {data[W-1:0], g, r, s}, W+3 bits. A remaining-shift counter `rem` and a `count` register sit alongside it.
- Accepting start (IDLE with start=1) does the following:
  - loads E = {unshifted, grs_in};
  - loads rem = no_of_shifts;
  - clears count, zero and limited;
  - asserts busy.
- LOAD_CHECK, right mode:
  - If no_of_shifts ≥ W+3, the shift saturates. E becomes {0, 0, 0, s'}, where s' is the OR of all of E. count = no_of_shifts, then go to DONE.
  - Otherwise go to SHIFT.
- LOAD_CHECK, left mode:
  - If {data, g, r} == 0: set zero=1, leave E unchanged, count=0, then go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, right mode:
  - If rem == 0, go to DONE.
  - Otherwise shift E right by k = min(STEP, rem). The new s is the old s ORed with every bit shifted past s. Then rem -= k and count += k.
- SHIFT, left mode:
  - If data[W-1] == 1, go to DONE.
  - If rem == 0, set limited=1 and go to DONE.
  - Otherwise let z = the leading-zero count of the top STEP bits of {data, g, r}. Shift {data, g, r} left by k = min(STEP, z, rem), filling with 0. s is unchanged. Then rem -= k and count += k.
- DONE: pulse done, drop busy and return to IDLE.
- Outputs: shifted = E[W+2:3], grs = E[2:0], shift_count = count.
- All outputs hold their values until the next accepted start.
- start while busy=1 is ignored. No queueing, no effect on the operation in flight.
- Direction, unshifted, grs_in and no_of_shifts are sampled only on the accept edge. Changes during busy are ignored.

## Timing
- Reset (rst_n=0, any time, asynchronous):
  - state = IDLE;
  - E, rem and count = 0, so shifted=0, grs=0 and shift_count=0;
  - zero=0, limited=0, busy=0, done=0.
  - Any operation in flight is abandoned.
- Edge 1 is the accept edge. busy is high from edge 1 until the edge that enters IDLE.
- Right mode, N < W+3: done is high after edge ceil(N/STEP)+3. N=0 gives edge 3.
- Right mode, saturated (N ≥ W+3): done after edge 3.
- Left mode, L = min(leading zeros of {data, g, r}, limit): done after edge ceil-steps(L)+3. A zero input gives edge 3.
- done is high for exactly one cycle. The earliest new start is sampled on the edge that ends the done cycle.

## Structure
- Package fp_shift_pkg:
  - state enum {IDLE, LOAD_CHECK, SHIFT, DONE};
  - DIR_RIGHT=1'b1 and DIR_LEFT=1'b0;
  - function grs_width() = 3.
- Sub-module step_lzc (parameter STEP): combinational leading-zero count over STEP bits, output clamped to STEP. Instantiated once for the left-mode step size.
- The main module contains the FSM, the E/rem/count registers and the sticky-OR shift logic.

## Test plan
Configuration for all scenarios: Mantissa_Size=7 (W=8), Exponent_Size=5, STEP=2.
- Right align: unshifted=8'b1011_0111, grs_in=0, N=3 -> shifted=8'b0001_0110, grs=3'b111, shift_count=3, done after edge 5.
- Right saturate: unshifted=8'h01, N=20 -> shifted=0, grs=3'b001, shift_count=20, done after edge 3.
- Left normalise: unshifted=8'b0000_0101, grs_in=3'b100, limit=31 -> shifted=8'b1011_0000, grs=3'b000, shift_count=5, limited=0.
- Left limited: same input, limit=2 -> shifted=8'b0001_0110, grs=3'b000, shift_count=2, limited=1.
- Left zero: unshifted=0, grs_in=3'b001 -> zero=1, shifted=0, grs=3'b001, shift_count=0, done after edge 3.
- Control edge cases:
  - A second start pulse during busy is ignored and the first result is unchanged.
  - rst_n low mid-SHIFT forces every output to its reset value immediately.
  - After reset, a new start completes normally.
